acc_framer: RTL
===============

ACC_FRAMER -- requirements
Module: acc_framer

Interface
REQ-001 Parameter W_DATA, default 16, width of data and offset fields.
REQ-002 Parameter W_LEN, default 8, width of frame-length field and beat counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg  dti.consumer  W_DATA+W_LEN  frame descriptor; {offset[W_DATA], len[W_LEN]}, len in the LSBs.
REQ-006 din  dti.consumer  W_DATA  raw sample stream.
REQ-007 dout  dti.producer  1+2*W_DATA  tagged beat {eot, offset, data}; eot is the MSB, data is in the LSBs; this is the accumulator stage's input layout.

Function
REQ-008 The block SHALL implement two states, IDLE and FRAME, with IDLE as the reset state.
REQ-009 In IDLE: cfg.ready=1 and din.ready=0.
REQ-010 In FRAME: cfg.ready=0 and din.ready = !dout.valid || dout.ready.
REQ-011 On a cfg handshake in IDLE, the block SHALL latch offset, latch len_eff = (len==0 ? 1 : len), clear the beat counter cnt, and enter FRAME next cycle.
REQ-012 On a din handshake in FRAME, dout.data SHALL register {cnt==len_eff-1, offset_latched, din.data} and dout.valid SHALL be set next cycle (latency 1).
REQ-013 cnt SHALL increment by 1 on each din handshake; cnt is W_LEN bits and never wraps, since it is cleared when eot is issued.
REQ-014 On the din handshake carrying eot=1, the state SHALL return to IDLE next cycle; a new cfg is accepted no earlier than that cycle (minimum one bubble between frames).
REQ-015 dout.valid and dout.data SHALL stay stable while dout.valid=1 and dout.ready=0.
REQ-016 dout.valid SHALL clear after a dout handshake unless a din handshake occurs in the same cycle, in which case the new beat replaces it (full throughput, 1 beat/cycle).
REQ-017 The last beat of a frame MAY still be pending on dout while in IDLE; a cfg accepted in that state SHALL NOT alter the pending beat.
REQ-018 Frame length range: 1 .. 2^W_LEN-1 beats; len=0 SHALL behave exactly as len=1.
REQ-019 din valid while in IDLE SHALL be ignored (no handshake, no state change).

Reset
REQ-020 During rst: state=IDLE, cnt=0, offset_latched=0, len_eff=0, dout.valid=0, dout.data=0.
REQ-021 rst asserted mid-frame SHALL abort the frame with no eot beat emitted; the first cycle after reset SHALL show cfg.ready=1.
REQ-022 rst SHALL override any simultaneous handshake.

Structure
REQ-023 A shared package acc_framer_pkg SHALL hold the typedefs cfg_t {offset, len} and beat_t {eot, offset, data}, parameterised via W_DATA/W_LEN.
REQ-024 The output register with its valid/ready logic SHALL be a sub-module named framer_out_reg; the FSM and counter SHALL live in acc_framer.

Verification
REQ-025 Single frame: cfg {offset=5, len=3}, din 1,2,3 with dout.ready=1 -> dout {0,5,1},{0,5,2},{1,5,3}, each 1 cycle after its din handshake.
REQ-026 len=0: cfg {offset=7, len=0}, din 9 -> single dout {1,7,9}; state returns to IDLE.
REQ-027 Backpressure: dout.ready=0 for 4 cycles mid-frame -> din.ready=0 after one buffered beat; dout holds its value; no beat is lost or duplicated when ready rises.
REQ-028 Back-to-back frames: cfg {2,2} then {10,1}, din 4,5,6, continuous valid -> {0,2,4},{1,2,5},{1,10,6}; exactly one IDLE cycle between the frames.
REQ-029 Reset mid-frame: cfg {1,4}, 2 beats, then rst for 1 cycle -> dout.valid=0 and cfg.ready=1 after reset; a new cfg {3,1} with din 8 -> {1,3,8}.
REQ-030 Max length: W_LEN=8, len=255, 255 beats -> eot set only on beat 255 and cnt never wraps.

Source files
------------

// File: rtl/acc_framer_pkg.sv
// Shared types for the accumulator framer: descriptor and tagged-beat layouts plus FSM states.
package acc_framer_pkg;

    localparam int unsigned W_DATA = 16;
    localparam int unsigned W_LEN  = 8;

    // Descriptor as seen on the cfg channel; len sits in the LSBs.
    typedef struct packed {
        logic [W_DATA-1:0] offset;
        logic [W_LEN-1:0]  len;
    } cfg_t;

    // Beat as consumed by the accumulator stage; eot is the MSB, data the LSBs.
    typedef struct packed {
        logic              eot;
        logic [W_DATA-1:0] offset;
        logic [W_DATA-1:0] data;
    } beat_t;

    typedef enum logic {
        StIdle,
        StFrame
    } state_e;

endpackage

// File: rtl/acc_framer_if.sv
// Valid/ready data channel used for the framer's descriptor, sample and beat streams.
interface acc_framer_if #(
    parameter int unsigned W = 8
) ();

    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
    modport master   (output valid, output data, input ready);
    modport slave    (input valid, input data, output ready);

endinterface

// File: rtl/framer_out_reg.sv
// Single-entry output register with valid/ready; accepts a new beat in the same cycle
// the held one drains, so the stream runs at one beat per cycle.
module framer_out_reg #(
    parameter int unsigned W = 33
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [W-1:0]    load_data,
    output logic            can_load,
    acc_framer_if.producer  dout
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (dout.ready) begin
            valid_q <= 1'b0;
        end
    end

    assign can_load   = !valid_q || dout.ready;
    assign dout.valid = valid_q;
    assign dout.data  = data_q;

endmodule

// File: rtl/acc_framer.sv
// Frames a raw sample stream: tags each sample with the descriptor's offset and marks the
// last beat of the frame with eot.
module acc_framer #(
    parameter int unsigned W_DATA = 16,
    parameter int unsigned W_LEN  = 8
) (
    input  logic            clk,
    input  logic            rst,
    acc_framer_if.consumer  cfg,
    acc_framer_if.consumer  din,
    acc_framer_if.producer  dout
);

    import acc_framer_pkg::*;

    state_e              state_q, state_d;
    logic [W_LEN-1:0]    cnt_q, cnt_d;
    logic [W_LEN-1:0]    len_q, len_d;
    logic [W_DATA-1:0]   off_q, off_d;

    logic [W_LEN-1:0]    cfg_len;
    logic [W_DATA-1:0]   cfg_off;
    logic                cfg_hs;
    logic                din_hs;
    logic                can_load;
    logic                eot;
    logic [2*W_DATA:0]   beat;

    assign cfg_len = cfg.data[W_LEN-1:0];
    assign cfg_off = cfg.data[W_LEN +: W_DATA];

    always_comb begin
        cfg.ready = 1'b0;
        din.ready = 1'b0;
        if (state_q == StIdle) begin
            cfg.ready = 1'b1;
        end else begin
            din.ready = can_load;
        end
    end

    assign cfg_hs = cfg.valid && cfg.ready;
    assign din_hs = din.valid && din.ready;
    assign eot    = (cnt_q == len_q - W_LEN'(1));
    assign beat   = {eot, off_q, din.data};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        off_d   = off_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_hs) begin
                    off_d   = cfg_off;
                    // A zero-length descriptor still carries one beat.
                    len_d   = (cfg_len == '0) ? W_LEN'(1) : cfg_len;
                    cnt_d   = '0;
                    state_d = StFrame;
                end
            end
            StFrame: begin
                if (din_hs) begin
                    if (eot) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + W_LEN'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            off_q   <= off_d;
        end
    end

    framer_out_reg #(
        .W (1 + 2 * W_DATA)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (din_hs),
        .load_data (beat),
        .can_load  (can_load),
        .dout      (dout)
    );

endmodule
